// File: rtl/score_level_engine.sv
// Score/level engine for a falling-block game: scoring, level advance, game FSM.
// Optional high-score register enabled by defining SCORE_HISCORE_EN.
module score_level_engine #(
   parameter int unsigned SCORE_W         = 16,
   parameter int unsigned LEVEL_W         = 4,
   parameter int unsigned LINES_PER_LEVEL = 10,
   parameter int unsigned MAX_LEVEL       = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               clear_valid,
   input  logic [2:0]         lines_cleared,
   input  logic               game_over,
   input  logic               restart_game,
   output logic [SCORE_W-1:0] player_score,
   output logic [LEVEL_W-1:0] current_level,
   output logic [15:0]        total_lines,
   output logic               level_up,
   output logic [1:0]         game_state,
   output logic [SCORE_W-1:0] high_score
);

   localparam int unsigned BASE_W = 11;
   localparam int unsigned LVL1_W = LEVEL_W + 1;
   localparam int unsigned PROD_W = BASE_W + LVL1_W;
   localparam int unsigned SUM_W  = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;
   localparam int unsigned CNT_W  = $clog2(LINES_PER_LEVEL + 8) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_OVER = 2'b10
   } state_t;

   state_t             r_state,        w_state_nxt;
   logic [SCORE_W-1:0] r_score,        w_score_nxt;
   logic [LEVEL_W-1:0] r_level,        w_level_nxt;
   logic [CNT_W-1:0]   r_lines_in_lvl, w_lines_in_lvl_nxt;
   logic [15:0]        r_total,        w_total_nxt;
   logic               r_level_up,     w_level_up_nxt;

   logic [BASE_W-1:0]  w_base;
   logic [LVL1_W-1:0]  w_level_p1;
   logic [PROD_W-1:0]  w_points;
   logic [SUM_W-1:0]   w_score_sum;
   logic [SCORE_W-1:0] w_score_sat;
   logic [16:0]        w_total_sum;
   logic [15:0]        w_total_sat;
   logic [CNT_W-1:0]   w_lvl_sum;
   logic               w_lvl_wrap;
   logic               w_at_max;
   logic               w_clear_ok;

   // Base points per clear size; zero for the ignored sizes
   always_comb begin
      w_base = '0;
      case (lines_cleared)
         3'd1:    w_base = BASE_W'(40);
         3'd2:    w_base = BASE_W'(100);
         3'd3:    w_base = BASE_W'(300);
         3'd4:    w_base = BASE_W'(1200);
         default: w_base = '0;
      endcase
   end

   assign w_clear_ok  = clear_valid && (lines_cleared != 3'd0) && (lines_cleared <= 3'd4);
   assign w_level_p1  = LVL1_W'(r_level) + LVL1_W'(1);
   assign w_points    = PROD_W'(w_base) * PROD_W'(w_level_p1);
   assign w_score_sum = SUM_W'(r_score) + SUM_W'(w_points);
   assign w_score_sat = (|w_score_sum[SUM_W-1:SCORE_W]) ? '1 : w_score_sum[SCORE_W-1:0];
   assign w_total_sum = 17'(r_total) + 17'(lines_cleared);
   assign w_total_sat = w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
   assign w_lvl_sum   = r_lines_in_lvl + CNT_W'(lines_cleared);
   assign w_lvl_wrap  = (w_lvl_sum >= CNT_W'(LINES_PER_LEVEL));
   assign w_at_max    = (r_level >= LEVEL_W'(MAX_LEVEL));

   // State and datapath register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_score        <= '0;
         r_level        <= '0;
         r_lines_in_lvl <= '0;
         r_total        <= '0;
         r_level_up     <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_score        <= w_score_nxt;
         r_level        <= w_level_nxt;
         r_lines_in_lvl <= w_lines_in_lvl_nxt;
         r_total        <= w_total_nxt;
         r_level_up     <= w_level_up_nxt;
      end
   end

   // Next state; restart beats game_over beats a clear
   always_comb begin
      w_state_nxt        = r_state;
      w_score_nxt        = r_score;
      w_level_nxt        = r_level;
      w_lines_in_lvl_nxt = r_lines_in_lvl;
      w_total_nxt        = r_total;
      w_level_up_nxt     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            if (restart_game) begin
               w_state_nxt        = ST_IDLE;
               w_score_nxt        = '0;
               w_level_nxt        = '0;
               w_lines_in_lvl_nxt = '0;
               w_total_nxt        = '0;
            end else if (game_over) begin
               w_state_nxt = ST_OVER;
            end else if (w_clear_ok) begin
               w_score_nxt        = w_score_sat;
               w_total_nxt        = w_total_sat;
               w_lines_in_lvl_nxt = w_lvl_sum;
               if (w_lvl_wrap) begin
                  w_lines_in_lvl_nxt = w_lvl_sum - CNT_W'(LINES_PER_LEVEL);
                  if (!w_at_max) begin
                     w_level_nxt    = r_level + LEVEL_W'(1);
                     w_level_up_nxt = 1'b1;
                  end
               end
            end
         end
         ST_OVER: begin
            if (restart_game) begin
               w_state_nxt        = ST_IDLE;
               w_score_nxt        = '0;
               w_level_nxt        = '0;
               w_lines_in_lvl_nxt = '0;
               w_total_nxt        = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

`ifdef SCORE_HISCORE_EN
   logic [SCORE_W-1:0] r_high_score;

   // Best score captured as a game ends
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_high_score <= '0;
      end else if ((r_state == ST_PLAY) && (w_state_nxt == ST_OVER) &&
                   (r_score > r_high_score)) begin
         r_high_score <= r_score;
      end
   end

   assign high_score = r_high_score;
`else
   assign high_score = '0;
`endif

   assign player_score  = r_score;
   assign current_level = r_level;
   assign total_lines   = r_total;
   assign level_up      = r_level_up;
   assign game_state    = r_state;

endmodule

// File: tb/tb_score_level_engine.sv
// Bench for score_level_engine: directed scenarios plus random play against a
// game-rules model; a second instance with SCORE_W=8 exercises saturation.
module tb_score_level_engine;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        clear_valid = 1'b0;
   logic [2:0]  lines_cleared = 3'd0;
   logic        game_over = 1'b0;
   logic        restart_game = 1'b0;

   logic [15:0] ps, tl, hs;
   logic [3:0]  cl;
   logic        lu;
   logic [1:0]  gs;
   logic [7:0]  ps8, hs8;
   logic [3:0]  cl8;
   logic [15:0] tl8;
   logic        lu8;
   logic [1:0]  gs8;

   int n_checks = 0;
   int n_errors = 0;

   // Game model
   int     m_state, m_level, m_inlvl, m_total;
   longint m_score, m_high;
   bit     m_lvlup;
   int     base_pts [5] = '{0, 40, 100, 300, 1200};

   score_level_engine u_dut (
      .clock(clock), .reset(reset), .start(start), .clear_valid(clear_valid),
      .lines_cleared(lines_cleared), .game_over(game_over), .restart_game(restart_game),
      .player_score(ps), .current_level(cl), .total_lines(tl), .level_up(lu),
      .game_state(gs), .high_score(hs)
   );

   score_level_engine #(.SCORE_W(8)) u_dut8 (
      .clock(clock), .reset(reset), .start(start), .clear_valid(clear_valid),
      .lines_cleared(lines_cleared), .game_over(game_over), .restart_game(restart_game),
      .player_score(ps8), .current_level(cl8), .total_lines(tl8), .level_up(lu8),
      .game_state(gs8), .high_score(hs8)
   );

   always #5 clock = ~clock;

   function automatic longint sat(longint v, longint mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic longint exp_high(longint mx);
`ifdef SCORE_HISCORE_EN
      return sat(m_high, mx);
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_state = 0; m_level = 0; m_inlvl = 0; m_total = 0;
      m_score = 0; m_high = 0; m_lvlup = 0;
   endtask

   // One clock edge of the game rules, applied to the currently driven inputs
   task automatic model_step();
      int n;
      n = int'(lines_cleared);
      m_lvlup = 0;
      if (m_state != 0 && restart_game) begin
         m_state = 0; m_score = 0; m_level = 0; m_total = 0; m_inlvl = 0;
      end else if (m_state == 0) begin
         if (start) m_state = 1;
      end else if (m_state == 1) begin
         if (game_over) begin
            m_state = 2;
            if (m_score > m_high) m_high = m_score;
         end else if (clear_valid && n >= 1 && n <= 4) begin
            m_score += longint'(base_pts[n]) * longint'(m_level + 1);
            m_total = int'(sat(longint'(m_total + n), 65535));
            m_inlvl += n;
            if (m_inlvl >= 10) begin
               m_inlvl -= 10;
               if (m_level < 15) begin
                  m_level++;
                  m_lvlup = 1;
               end
            end
         end
      end
   endtask

   task automatic drive(bit s, bit cv, int l, bit go, bit rs);
      start = s; clear_valid = cv; lines_cleared = 3'(l);
      game_over = go; restart_game = rs;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic step(bit s, bit cv, int l, bit go, bit rs);
      drive(s, cv, l, go, rs);
      tick();
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (gs !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", gs); end
      n_checks++; if (ps !== 16'd0) begin n_errors++; $display("FAIL reset_score: got %0d expected 0", ps); end
      n_checks++; if (cl !== 4'd0) begin n_errors++; $display("FAIL reset_level: got %0d expected 0", cl); end
      n_checks++; if (tl !== 16'd0) begin n_errors++; $display("FAIL reset_lines: got %0d expected 0", tl); end
      n_checks++; if (lu !== 1'b0) begin n_errors++; $display("FAIL reset_level_up: got %0d expected 0", lu); end
      n_checks++; if (hs !== 16'd0) begin n_errors++; $display("FAIL reset_high: got %0d expected 0", hs); end
      model_reset();
      @(negedge clock) reset = 1'b0;
      step(0, 1, 2, 0, 0);
      step(0, 0, 0, 1, 0);
      n_checks++; if (gs !== 2'd0) begin n_errors++; $display("FAIL idle_wait: got %0d expected 0", gs); end
   endtask

   task automatic test_first_clear();
      step(1, 0, 0, 0, 0);
      n_checks++; if (gs !== 2'd1) begin n_errors++; $display("FAIL start_play: got %0d expected 1", gs); end
      drive(0, 1, 2, 0, 0);
      n_checks++; if (ps !== 16'd0) begin n_errors++; $display("FAIL pre_edge_score: got %0d expected 0", ps); end
      tick();
      drive(0, 0, 0, 0, 0);
      n_checks++; if (ps !== 16'd100) begin n_errors++; $display("FAIL two_line_score: got %0d expected 100", ps); end
      n_checks++; if (tl !== 16'd2) begin n_errors++; $display("FAIL two_line_total: got %0d expected 2", tl); end
   endtask

   task automatic test_level_up();
      int pulses;
      pulses = 0;
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 1, 0, 0);
         pulses += int'(lu);
      end
      n_checks++; if (lu !== 1'b1) begin n_errors++; $display("FAIL level_up_edge: got %0d expected 1", lu); end
      step(0, 0, 0, 0, 0);
      pulses += int'(lu);
      n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL level_up_pulses: got %0d expected 1", pulses); end
      n_checks++; if (cl !== 4'd1) begin n_errors++; $display("FAIL level_one: got %0d expected 1", cl); end
      n_checks++; if (ps !== 16'd400) begin n_errors++; $display("FAIL ten_singles: got %0d expected 400", ps); end
      step(0, 1, 4, 0, 0);
      n_checks++; if (ps !== 16'd2800) begin n_errors++; $display("FAIL tetris_lvl1: got %0d expected 2800", ps); end
      n_checks++; if (ps8 !== 8'd255) begin n_errors++; $display("FAIL small_sat_lvl1: got %0d expected 255", ps8); end
   endtask

   task automatic test_saturation();
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      step(0, 1, 4, 0, 0);
      n_checks++; if (ps8 !== 8'd255) begin n_errors++; $display("FAIL sat8_first: got %0d expected 255", ps8); end
      n_checks++; if (ps !== 16'd1200) begin n_errors++; $display("FAIL wide_tetris: got %0d expected 1200", ps); end
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0);
      n_checks++; if (ps8 !== 8'd255) begin n_errors++; $display("FAIL sat8_hold: got %0d expected 255", ps8); end
      n_checks++; if (ps !== 16'(m_score)) begin n_errors++; $display("FAIL wide_after_sat: got %0d expected %0d", ps, m_score); end
   endtask

   task automatic test_gameover_drop();
      logic [15:0] s0, t0;
      s0 = ps; t0 = tl;
      step(0, 1, 3, 1, 0);
      n_checks++; if (gs !== 2'd2) begin n_errors++; $display("FAIL over_state: got %0d expected 2", gs); end
      n_checks++; if (ps !== s0) begin n_errors++; $display("FAIL over_drop_score: got %0d expected %0d", ps, s0); end
      n_checks++; if (tl !== t0) begin n_errors++; $display("FAIL over_drop_lines: got %0d expected %0d", tl, t0); end
      step(1, 1, 2, 1, 0);
      n_checks++; if (ps !== s0 || gs !== 2'd2) begin n_errors++; $display("FAIL over_hold: got %0d/%0d expected %0d/2", ps, gs, s0); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (gs !== 2'd0) begin n_errors++; $display("FAIL restart_idle: got %0d expected 0", gs); end
      n_checks++; if (ps !== 16'd0 || tl !== 16'd0 || cl !== 4'd0) begin n_errors++; $display("FAIL restart_zero: got %0d/%0d/%0d expected 0/0/0", ps, tl, cl); end
   endtask

   task automatic test_hiscore();
      longint e;
      apply_reset();
      step(1, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0);
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0);
      step(0, 0, 0, 1, 0);
`ifdef SCORE_HISCORE_EN
      e = 300;
`else
      e = 0;
`endif
      n_checks++; if (hs !== 16'(e)) begin n_errors++; $display("FAIL high_score: got %0d expected %0d", hs, e); end
      n_checks++; if (hs8 !== 8'(sat(e, 255))) begin n_errors++; $display("FAIL high_score8: got %0d expected %0d", hs8, sat(e, 255)); end
      step(0, 0, 0, 0, 1);
   endtask

   task automatic test_async_reset();
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 4, 0, 0);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (gs !== 2'd0 || ps !== 16'd0 || cl !== 4'd0 || tl !== 16'd0 || lu !== 1'b0 || hs !== 16'd0)
         begin n_errors++; $display("FAIL async_reset: got st%0d sc%0d lv%0d ln%0d lu%0d hs%0d expected all 0", gs, ps, cl, tl, lu, hs); end
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic test_max_level();
      int pulses;
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         step(0, 1, 4, 0, 0);
         n_checks++; if (cl !== 4'(m_level) || lu !== m_lvlup) begin n_errors++; $display("FAIL climb_%0d: got lv%0d lu%0d expected lv%0d lu%0d", i, cl, lu, m_level, m_lvlup); end
      end
      n_checks++; if (cl !== 4'd15) begin n_errors++; $display("FAIL max_level: got %0d expected 15", cl); end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 4, 0, 0);
         pulses += int'(lu);
      end
      n_checks++; if (pulses != 0 || cl !== 4'd15) begin n_errors++; $display("FAIL max_no_pulse: got %0d pulses lv%0d expected 0 lv15", pulses, cl); end
   endtask

   task automatic test_total_sat();
      for (int i = 0; i < 16400; i++) step(0, 1, 4, 0, 0);
      n_checks++; if (tl !== 16'hFFFF) begin n_errors++; $display("FAIL total_sat: got %0d expected 65535", tl); end
      n_checks++; if (ps !== 16'hFFFF) begin n_errors++; $display("FAIL score_sat16: got %0d expected 65535", ps); end
      step(0, 0, 0, 0, 1);
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom % 4) == 0, ($urandom % 4) != 0, int'($urandom % 8),
               ($urandom % 120) == 0, ($urandom % 200) == 0);
         tick();
         n_checks++; if (gs !== 2'(m_state)) begin n_errors++; $display("FAIL rnd_state @%0d: got %0d expected %0d", i, gs, m_state); end
         n_checks++; if (ps !== 16'(sat(m_score, 65535))) begin n_errors++; $display("FAIL rnd_score @%0d: got %0d expected %0d", i, ps, sat(m_score, 65535)); end
         n_checks++; if (ps8 !== 8'(sat(m_score, 255))) begin n_errors++; $display("FAIL rnd_score8 @%0d: got %0d expected %0d", i, ps8, sat(m_score, 255)); end
         n_checks++; if (cl !== 4'(m_level) || lu !== m_lvlup) begin n_errors++; $display("FAIL rnd_level @%0d: got lv%0d lu%0d expected lv%0d lu%0d", i, cl, lu, m_level, m_lvlup); end
         n_checks++; if (tl !== 16'(m_total)) begin n_errors++; $display("FAIL rnd_lines @%0d: got %0d expected %0d", i, tl, m_total); end
         n_checks++; if (hs !== 16'(exp_high(65535)) || hs8 !== 8'(exp_high(255))) begin n_errors++; $display("FAIL rnd_high @%0d: got %0d/%0d expected %0d/%0d", i, hs, hs8, exp_high(65535), exp_high(255)); end
      end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_clear();
      test_level_up();
      test_saturation();
      test_gameover_drop();
      test_hiscore();
      test_async_reset();
      test_max_level();
      test_total_sat();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
